// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
//
// A three-state FSM (idle -> exec -> resp) grants one requester at a time,
// latches its operands, drives them to the ALU for one cycle and captures the
// result and flags. It then holds a one-hot response until the owner accepts.
// Contended grants are arbitrated by a 1-bit priority pointer. The pointer
// moves to the other requester when a contended transaction completes.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req_valid[1:0]               per-requester request valid
//   req_a0/req_b0, req_a1/req_b1 requester operands (W bits)
//   req_op0, req_op1             requester opcodes (Ops bits)
//   req_sc0, req_sc1             requester shift/carry-in
//   req_ready[1:0]               per-requester accept (at most one bit high)
//   rsp_valid[1:0]               one-hot response valid, addressed to the owner
//   rsp_ready[1:0]               per-requester response accept
//   rsp_out, rsp_zero,
//   rsp_parity, rsp_odd          registered ALU result and flags
//   alu_a, alu_b, alu_op, alu_sc drive to the shared ALU (zero outside exec)
//   alu_out, alu_zero,
//   alu_parity, alu_odd          combinational results from the shared ALU
module alu_arbiter #(
  parameter int unsigned W   = 8,
  parameter int unsigned Ops = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  // requester side
  input  logic [1:0]     req_valid,
  input  logic [W-1:0]   req_a0,
  input  logic [W-1:0]   req_b0,
  input  logic [W-1:0]   req_a1,
  input  logic [W-1:0]   req_b1,
  input  logic [Ops-1:0] req_op0,
  input  logic [Ops-1:0] req_op1,
  input  logic           req_sc0,
  input  logic           req_sc1,
  output logic [1:0]     req_ready,
  // response side
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_out,
  output logic           rsp_zero,
  output logic           rsp_parity,
  output logic           rsp_odd,
  // shared ALU
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [Ops-1:0] alu_op,
  output logic           alu_sc,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_zero,
  input  logic           alu_parity,
  input  logic           alu_odd
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           prio_q;
  logic           owner_q;
  logic           contended_q;
  logic [W-1:0]   op_a_q;
  logic [W-1:0]   op_b_q;
  logic [Ops-1:0] op_op_q;
  logic           op_sc_q;
  logic [W-1:0]   rsp_out_q;
  logic           rsp_zero_q;
  logic           rsp_parity_q;
  logic           rsp_odd_q;

  logic           grant;
  logic           grant_idx;
  logic           both_valid;
  logic           rsp_done;

  assign both_valid = &req_valid;

  // Next-state, grant selection and handshake decode.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    grant     = 1'b0;
    grant_idx = 1'b0;
    rsp_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Contended: the pointer decides. Otherwise the lone requester wins.
        grant_idx = both_valid ? prio_q : req_valid[1];
        if (|req_valid) begin
          grant     = 1'b1;
          req_ready = grant_idx ? 2'b10 : 2'b01;
          state_d   = StExec;
        end
      end
      StExec: begin
        state_d = StResp;
      end
      StResp: begin
        // Only the owner's ready bit can complete the response.
        if (rsp_ready[owner_q]) begin
          rsp_done = 1'b1;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      contended_q  <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_op_q      <= '0;
      op_sc_q      <= 1'b0;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_parity_q <= 1'b0;
      rsp_odd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q     <= grant_idx;
        contended_q <= both_valid;
        op_a_q      <= grant_idx ? req_a1  : req_a0;
        op_b_q      <= grant_idx ? req_b1  : req_b0;
        op_op_q     <= grant_idx ? req_op1 : req_op0;
        op_sc_q     <= grant_idx ? req_sc1 : req_sc0;
      end
      if (state_q == StExec) begin
        rsp_out_q    <= alu_out;
        rsp_zero_q   <= alu_zero;
        rsp_parity_q <= alu_parity;
        rsp_odd_q    <= alu_odd;
      end
      // An uncontended service leaves the pointer where it was.
      if (rsp_done && contended_q) begin
        prio_q <= ~owner_q;
      end
    end
  end

  // ALU sees operands only during exec, zeros otherwise.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    alu_sc = 1'b0;
    if (state_q == StExec) begin
      alu_a  = op_a_q;
      alu_b  = op_b_q;
      alu_op = op_op_q;
      alu_sc = op_sc_q;
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == StResp) begin
      rsp_valid = owner_q ? 2'b10 : 2'b01;
    end
  end

  assign rsp_out    = rsp_out_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_parity = rsp_parity_q;
  assign rsp_odd    = rsp_odd_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int unsigned W   = 8;
  localparam int unsigned Ops = 3;

  // ALU opcode encoding used by the bench's ALU model
  localparam logic [Ops-1:0] OpAdd = 3'd0;
  localparam logic [Ops-1:0] OpSub = 3'd1;
  localparam logic [Ops-1:0] OpAnd = 3'd2;
  localparam logic [Ops-1:0] OpOrr = 3'd3;
  localparam logic [Ops-1:0] OpXor = 3'd4;
  localparam logic [Ops-1:0] OpLsh = 3'd5;
  localparam logic [Ops-1:0] OpRsh = 3'd6;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [1:0]     req_valid;
  logic [W-1:0]   req_a0, req_b0, req_a1, req_b1;
  logic [Ops-1:0] req_op0, req_op1;
  logic           req_sc0, req_sc1;
  logic [1:0]     req_ready;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_out;
  logic           rsp_zero, rsp_parity, rsp_odd;
  logic [W-1:0]   alu_a, alu_b;
  logic [Ops-1:0] alu_op;
  logic           alu_sc;
  logic [W-1:0]   alu_out;
  logic           alu_zero, alu_parity, alu_odd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .Ops(Ops)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_sc0    (req_sc0),
    .req_sc1    (req_sc1),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_zero   (rsp_zero),
    .rsp_parity (rsp_parity),
    .rsp_odd    (rsp_odd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_sc     (alu_sc),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .alu_parity (alu_parity),
    .alu_odd    (alu_odd)
  );

  // Shared combinational ALU model
  always_comb begin
    alu_out = '0;
    case (alu_op)
      OpAdd:   alu_out = alu_a + alu_b + {7'd0, alu_sc};
      OpSub:   alu_out = alu_a - alu_b;
      OpAnd:   alu_out = alu_a & alu_b;
      OpOrr:   alu_out = alu_a | alu_b;
      OpXor:   alu_out = alu_a ^ alu_b;
      OpLsh:   alu_out = (alu_a << alu_b[2:0]) | {7'd0, alu_sc};
      OpRsh:   alu_out = alu_a >> alu_b[2:0];
      default: alu_out = alu_a;
    endcase
    alu_zero   = (alu_out == '0);
    alu_parity = ^alu_out;
    alu_odd    = alu_out[0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2 time units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_op0 = '0; req_op1 = '0; req_sc0 = 1'b0; req_sc1 = 1'b0;
    rsp_ready = 2'b00;

    // Reset state
    tick(); tick();
    check("rst_req_ready", {30'd0, req_ready}, 32'h0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'h0);
    check("rst_rsp_out", {24'd0, rsp_out}, 32'h0);
    check("rst_flags", {29'd0, rsp_zero, rsp_parity, rsp_odd}, 32'h0);
    check("rst_alu_a", {24'd0, alu_a}, 32'h0);
    reset_n = 1'b1;
    tick();
    check("post_rst_rsp_valid", {30'd0, rsp_valid}, 32'h0);

    // Single op: requester 0 ADD 05 + 03
    req_valid = 2'b01; req_op0 = OpAdd; req_a0 = 8'h05; req_b0 = 8'h03;
    settle();
    check("single_req_ready", {30'd0, req_ready}, 32'h1);
    check("single_idle_alu_a", {24'd0, alu_a}, 32'h0);
    tick();
    req_valid = 2'b00;
    settle();
    check("single_exec_req_ready", {30'd0, req_ready}, 32'h0);
    check("single_exec_alu_ab", {16'd0, alu_a, alu_b}, 32'h0503);
    check("single_exec_rsp_valid", {30'd0, rsp_valid}, 32'h0);
    tick();
    check("single_rsp_valid", {30'd0, rsp_valid}, 32'h1);
    check("single_rsp_out", {24'd0, rsp_out}, 32'h08);
    check("single_flags_zpo", {29'd0, rsp_zero, rsp_parity, rsp_odd}, 32'h2);
    check("single_resp_alu_a", {24'd0, alu_a}, 32'h0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check("single_done_rsp_valid", {30'd0, rsp_valid}, 32'h0);

    // Shift op: requester 1 LSH 81 by 1
    req_valid = 2'b10; req_op1 = OpLsh; req_a1 = 8'h81; req_b1 = 8'h01;
    settle();
    check("shift_req_ready", {30'd0, req_ready}, 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    check("shift_rsp_valid", {30'd0, rsp_valid}, 32'h2);
    check("shift_rsp_out", {24'd0, rsp_out}, 32'h02);
    check("shift_flags_zpo", {29'd0, rsp_zero, rsp_parity, rsp_odd}, 32'h2);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    check("shift_done_rsp_valid", {30'd0, rsp_valid}, 32'h0);

    // Contention: 0 SUB 10-10, 1 ORR A0|05, both held valid
    req_valid = 2'b11;
    req_op0 = OpSub; req_a0 = 8'h10; req_b0 = 8'h10;
    req_op1 = OpOrr; req_a1 = 8'hA0; req_b1 = 8'h05;
    settle();
    check("cont_first_grant", {30'd0, req_ready}, 32'h1);
    tick();
    check("cont_exec_req_ready", {30'd0, req_ready}, 32'h0);
    check("cont_exec_alu_op", {29'd0, alu_op}, {29'd0, OpSub});
    tick();
    check("cont_rsp0_valid", {30'd0, rsp_valid}, 32'h1);
    check("cont_rsp0_out", {24'd0, rsp_out}, 32'h00);
    check("cont_rsp0_zero", {31'd0, rsp_zero}, 32'h1);

    // Back-pressure: owner not ready, non-owner ready bit must be ignored
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", {30'd0, rsp_valid}, 32'h1);
      check("bp_rsp_out", {24'd0, rsp_out}, 32'h00);
      check("bp_req_ready", {30'd0, req_ready}, 32'h0);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check("cont_second_grant", {30'd0, req_ready}, 32'h2);
    tick();
    check("cont_exec1_alu_a", {24'd0, alu_a}, 32'hA0);
    tick();
    check("cont_rsp1_valid", {30'd0, rsp_valid}, 32'h2);
    check("cont_rsp1_out", {24'd0, rsp_out}, 32'hA5);
    check("cont_rsp1_flags_zpo", {29'd0, rsp_zero, rsp_parity, rsp_odd}, 32'h1);
    rsp_ready = 2'b10;
    tick();
    // Pointer back at 0
    check("cont_prio_back_to_0", {30'd0, req_ready}, 32'h1);

    // Fairness: both valid, responses accepted at once -> 0,1,0,1 every 3 cycles
    rsp_ready = 2'b11;
    for (int k = 0; k < 12; k++) begin
      if (k % 3 == 0) begin
        check("fair_grant", {30'd0, req_ready}, ((k / 3) % 2 == 0) ? 32'h1 : 32'h2);
      end else begin
        check("fair_no_grant", {30'd0, req_ready}, 32'h0);
      end
      tick();
    end
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    settle();
    check("fair_end_idle", {30'd0, rsp_valid}, 32'h0);

    // Reset mid-op: abort during exec
    req_valid = 2'b01; req_op0 = OpAdd; req_a0 = 8'h01; req_b0 = 8'h01;
    tick();
    req_valid = 2'b00;
    settle();
    check("abort_exec_alu_a", {24'd0, alu_a}, 32'h01);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_rsp_valid", {30'd0, rsp_valid}, 32'h0);
    check("abort_alu_a", {24'd0, alu_a}, 32'h0);
    check("abort_rsp_out", {24'd0, rsp_out}, 32'h0);
    check("abort_req_ready", {30'd0, req_ready}, 32'h0);
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_rsp", {30'd0, rsp_valid}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter W, default 8: operand and result width in bits.
REQ-002 Parameter Ops, default 3: ALU opcode width in bits; opcode encoding comes from package definitions.
REQ-003 Clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 Reset_n  in  1  synchronous active-low reset, sampled on the rising edge of Clk.
REQ-005 ReqValid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-006 ReqA0/ReqB0, ReqA1/ReqB1  in  W each  requester operands.
REQ-007 ReqOp0, ReqOp1  in  Ops each  requester opcode.
REQ-008 ReqSC0, ReqSC1  in  1 each  requester shift/carry-in.
REQ-009 ReqReady  out  2  per-requester accept; at most one bit high.
REQ-010 RspValid  out  2  one-hot response valid, addressed to the served requester.
REQ-011 RspReady  in  2  per-requester response accept.
REQ-012 RspOut  out  W  registered result; RspZero, RspParity, RspOdd  out  1 each  registered flags.
REQ-013 AluA, AluB  out  W; AluOp  out  Ops; AluSC  out  1  drive to the shared ALU.
REQ-014 AluOut  in  W; AluZero, AluParity, AluOdd  in  1 each  combinational results from the shared ALU.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-016 In IDLE with one ReqValid bit high, the block SHALL assert only the matching ReqReady bit, combinationally.
REQ-017 In IDLE with both ReqValid bits high, the block SHALL assert ReqReady only for the requester named by the 1-bit priority pointer Prio.
REQ-018 In IDLE with no ReqValid bit high, ReqReady SHALL be 2'b00 and the state SHALL stay IDLE.
REQ-019 On the edge where ReqValid[i] and ReqReady[i] are both high, the block SHALL latch requester i's A, B, Op and SC, record i as owner, and enter EXEC.
REQ-020 ReqReady SHALL be 2'b00 in EXEC and RESP.
REQ-021 In EXEC, AluA/AluB/AluOp/AluSC SHALL equal the latched values; in IDLE and RESP they SHALL be all-zero.
REQ-022 At the end of the EXEC cycle, the block SHALL register AluOut and the three flags into RspOut and the flag outputs, and enter RESP.
REQ-023 In RESP, RspValid SHALL be one-hot on the owner bit; RspOut and the flags SHALL stay stable until the handshake.
REQ-024 RESP SHALL hold while RspReady[owner] is low; RspReady on the non-owner bit SHALL be ignored.
REQ-025 On the edge where RspValid[owner] and RspReady[owner] are both high, the block SHALL enter IDLE, set Prio to the non-owner requester, and drop RspValid to 2'b00.
REQ-026 Latency SHALL be exactly 2 cycles from the request handshake edge to first RspValid assertion.
REQ-027 Peak throughput SHALL be one operation per 3 cycles; a new grant is possible in the cycle after the response handshake.
REQ-028 Prio SHALL change only at the response handshake, never at grant and never when a single requester is served uncontended.
REQ-029 A requester dropping ReqValid while not granted SHALL have no effect; request inputs SHALL be ignored outside IDLE.
REQ-030 Width rules: all arithmetic is inside the ALU; the block SHALL pass through W-bit results and flags unmodified, with no truncation or extension.

Reset
REQ-031 With Reset_n low at a rising edge, the block SHALL set state to IDLE and Prio to 0.
REQ-032 The same reset SHALL clear the latched operands, owner, RspOut and all flags to 0.
REQ-033 During and after reset, all outputs SHALL be 0 until the next grant: ReqReady is combinational from ReqValid in IDLE, and RspValid is 2'b00.
REQ-034 Reset asserted in EXEC or RESP SHALL discard the transaction; no response SHALL ever be issued for it.

Verification
REQ-035 Single op: requester 0 sends ADD, A=8'h05, B=8'h03 -> ReqReady=2'b01 in the same cycle; 2 cycles later RspValid=2'b01 with RspOut=8'h08, Zero=0, Parity=1, Odd=0.
REQ-036 Contention: both requesters valid from reset (0: SUB 8'h10,8'h10; 1: ORR 8'hA0,8'h05). Required response:
- requester 0 served first with RspOut=8'h00 and Zero=1;
- requester 1 granted next with RspOut=8'hA5;
- then Prio=0.
REQ-037 Back-pressure: RspReady[0] held low for 5 cycles in RESP -> RspValid and RspOut stay stable, no new ReqReady, and RspReady[1]=1 is ignored.
REQ-038 Fairness: both requesters continuously valid for 12 cycles -> grants alternate 0,1,0,1, one grant per 3 cycles.
REQ-039 Reset mid-op: Reset_n low during EXEC -> next cycle IDLE, RspValid=2'b00, and no response is issued for the aborted operation.
REQ-040 Shift op: requester 1 sends LSH, A=8'h81, B=8'h01 -> RspOut=8'h02, Odd=0, Parity=1, and RspValid=2'b10.
